// File: rtl/ysyx_25040111_scoreboard.sv
// ysyx_25040111_scoreboard
//   Read-after-write scoreboard for the execute stage. Each architectural
//   register has a saturating pending-write counter. The counter goes up when
//   a tracked long-latency write issues and goes down when that write retires
//   on any retire channel. Issue is gated by hazards on sources, on the
//   destination (optional WAW stall) and by counter saturation.
//
//   Handshake: an issue transfers on a cycle where iss_valid and iss_ready
//   are both high. iss_ready is computed from the current inputs and the
//   counters only. It never depends on iss_valid through a loop, and the
//   requester must hold its request until the transfer happens.
//
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   iss_valid/iss_ready : issue handshake
//   iss_wen, iss_ard    : tracked destination write and its register
//   iss_asrc, iss_src_en: NSRC source registers (k at [k*AW +: AW]) and enables
//   ret_valid, ret_ard  : NRET retire strobes and retired registers
//   flush               : drop every pending write
//   busy                : per-register "counter non-zero"
//   hazard              : combinational stall reason
//   err                 : sticky retire-underflow flag
module ysyx_25040111_scoreboard #(
  parameter int NREG       = 16,
  parameter int AW         = 4,
  parameter int NSRC       = 2,
  parameter int NRET       = 2,
  parameter int CNTW       = 2,
  parameter int WAW_STALL  = 1,
  parameter int RET_BYPASS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic               iss_wen,
  input  logic [AW-1:0]      iss_ard,
  input  logic [NSRC*AW-1:0] iss_asrc,
  input  logic [NSRC-1:0]    iss_src_en,
  input  logic [NRET-1:0]    ret_valid,
  input  logic [NRET*AW-1:0] ret_ard,
  input  logic               flush,
  output logic [NREG-1:0]    busy,
  output logic               hazard,
  output logic               err
);

  // Wide enough to hold cnt + 1 and any retire count without wrapping.
  localparam int EW = CNTW + 2 + $clog2(NRET + 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0] cnt   [NREG];
  logic [EW-1:0]   dec   [NREG];
  logic [CNTW-1:0] eff   [NREG];
  logic [CNTW-1:0] nxt   [NREG];
  logic [NREG-1:0] under;
  logic            src_hit;
  logic            dst_hit;
  logic            sat;
  logic            fire;

  // Retires hitting each register this cycle, plus the value used for hazard
  // checks. With bypass, a retire in flight counts as already done.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      dec[r] = '0;
      for (int j = 0; j < NRET; j++) begin
        if (ret_valid[j] && (ret_ard[j*AW +: AW] == AW'(r))) begin
          dec[r] = dec[r] + EW'(1);
        end
      end
      if (RET_BYPASS != 0) begin
        if (dec[r] >= EW'(cnt[r])) begin
          eff[r] = '0;
        end else begin
          eff[r] = cnt[r] - CNTW'(dec[r]);
        end
      end else begin
        eff[r] = cnt[r];
      end
    end
  end

  // Saturation is checked on the stored count, not the bypassed one. This
  // keeps the increment path free of the retire path.
  always_comb begin
    src_hit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (iss_src_en[k] && (eff[iss_asrc[k*AW +: AW]] != '0)) begin
        src_hit = 1'b1;
      end
    end
    dst_hit = (WAW_STALL != 0) && iss_wen && (eff[iss_ard] != '0);
    sat     = iss_wen && (cnt[iss_ard] == CNT_MAX);
    hazard  = iss_valid && (src_hit || dst_hit || sat);
  end

  assign iss_ready = ~hazard & ~flush;
  assign fire      = iss_valid & iss_ready;

  // Next counter values. x0 is never tracked. A negative result clamps to 0
  // and raises the underflow flag.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic [EW-1:0] sum;
      sum      = EW'(cnt[r]);
      nxt[r]   = '0;
      under[r] = 1'b0;
      if (r != 0) begin
        if (fire && iss_wen && (iss_ard == AW'(r))) begin
          sum = sum + EW'(1);
        end
        if (dec[r] > sum) begin
          under[r] = 1'b1;
        end else begin
          nxt[r] = CNTW'(sum - dec[r]);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      err <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= nxt[r];
      end
      err <= err | (|under);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_scoreboard.sv
// tb_ysyx_25040111_scoreboard
//   Drives two scoreboards with the same stimulus. Instance a uses the
//   defaults (WAW stall, retire bypass). Instance b has both features off.
//   A per-instance reference model keeps integer pending counts and pushes
//   the expected {busy, err, hazard, iss_ready} for every driven cycle. A
//   monitor pops the expectations and compares them mid-cycle.
module tb_ysyx_25040111_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        iss_valid, iss_wen, flush;
  logic [3:0]  iss_ard;
  logic [7:0]  iss_asrc, ret_ard;
  logic [1:0]  iss_src_en, ret_valid;
  logic        ready_a, hazard_a, err_a, ready_b, hazard_b, err_b;
  logic [15:0] busy_a, busy_b;

  int          m_cnt [2][16];
  bit          m_err [2];
  logic [18:0] exp_q_a[$];
  logic [18:0] exp_q_b[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  ysyx_25040111_scoreboard u_a (
    .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_ready(ready_a),
    .iss_wen(iss_wen), .iss_ard(iss_ard), .iss_asrc(iss_asrc),
    .iss_src_en(iss_src_en), .ret_valid(ret_valid), .ret_ard(ret_ard),
    .flush(flush), .busy(busy_a), .hazard(hazard_a), .err(err_a)
  );

  ysyx_25040111_scoreboard #(.WAW_STALL(0), .RET_BYPASS(0)) u_b (
    .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_ready(ready_b),
    .iss_wen(iss_wen), .iss_ard(iss_ard), .iss_asrc(iss_asrc),
    .iss_src_en(iss_src_en), .ret_valid(ret_valid), .ret_ard(ret_ard),
    .flush(flush), .busy(busy_b), .hazard(hazard_b), .err(err_b)
  );

  // ---------------- reference model ----------------
  // Pending writes per register as plain integers. The model applies the
  // rules directly: the visible count is the stored count minus in-flight
  // retires (bypass) or just the stored count.
  task automatic model_step(input int d, output logic [18:0] exp_v);
    int          hits [16];
    int          vis  [16];
    bit          waw, byp, hz, rdy, fire;
    logic [15:0] bsy;
    int          n;
    waw = (d == 0);
    byp = (d == 0);
    for (int r = 0; r < 16; r++) hits[r] = 0;
    if (ret_valid[0]) hits[ret_ard[3:0]]++;
    if (ret_valid[1]) hits[ret_ard[7:4]]++;
    for (int r = 0; r < 16; r++) begin
      n      = m_cnt[d][r] - hits[r];
      vis[r] = byp ? ((n > 0) ? n : 0) : m_cnt[d][r];
      bsy[r] = (m_cnt[d][r] != 0);
    end
    hz = iss_valid && ((iss_src_en[0] && vis[iss_asrc[3:0]] != 0) ||
                       (iss_src_en[1] && vis[iss_asrc[7:4]] != 0) ||
                       (waw && iss_wen && vis[iss_ard] != 0) ||
                       (iss_wen && m_cnt[d][iss_ard] == 3));
    rdy   = !hz && !flush;
    fire  = iss_valid && rdy;
    exp_v = {bsy, m_err[d], hz, rdy};
    if (reset) begin
      for (int r = 0; r < 16; r++) m_cnt[d][r] = 0;
      m_err[d] = 1'b0;
    end else if (flush) begin
      for (int r = 0; r < 16; r++) m_cnt[d][r] = 0;
    end else begin
      for (int r = 1; r < 16; r++) begin
        n = m_cnt[d][r] + ((fire && iss_wen && iss_ard == 4'(r)) ? 1 : 0) - hits[r];
        if (n < 0) begin
          n        = 0;
          m_err[d] = 1'b1;
        end
        m_cnt[d][r] = n;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int v, input int wen, input int ard, input int s0,
                       input int s1, input int sen, input int rv, input int r0,
                       input int r1, input int fl, input int rst);
    logic [18:0] e;
    iss_valid  = v[0];
    iss_wen    = wen[0];
    iss_ard    = 4'(ard);
    iss_asrc   = {4'(s1), 4'(s0)};
    iss_src_en = 2'(sen);
    ret_valid  = 2'(rv);
    ret_ard    = {4'(r1), 4'(r0)};
    flush      = fl[0];
    reset      = rst[0];
    model_step(0, e);
    exp_q_a.push_back(e);
    model_step(1, e);
    exp_q_b.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string nm, input logic [18:0] e, input logic [18:0] g);
    n_cmp += 4;
    if (g[18:3] !== e[18:3]) begin
      n_bad++;
      $display("FAIL %s_busy t=%0t got=%h exp=%h", nm, $time, g[18:3], e[18:3]);
    end
    if (g[2] !== e[2]) begin
      n_bad++;
      $display("FAIL %s_err t=%0t got=%b exp=%b", nm, $time, g[2], e[2]);
    end
    if (g[1] !== e[1]) begin
      n_bad++;
      $display("FAIL %s_hazard t=%0t got=%b exp=%b", nm, $time, g[1], e[1]);
    end
    if (g[0] !== e[0]) begin
      n_bad++;
      $display("FAIL %s_ready t=%0t got=%b exp=%b", nm, $time, g[0], e[0]);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q_a.size() > 0) check("a", exp_q_a.pop_front(), {busy_a, err_a, hazard_a, ready_a});
    if (exp_q_b.size() > 0) check("b", exp_q_b.pop_front(), {busy_b, err_b, hazard_b, ready_b});
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 16; r++) m_cnt[d][r] = 0;
      m_err[d] = 1'b0;
    end
    reset = 1'b1; iss_valid = 1'b0; iss_wen = 1'b0; iss_ard = '0;
    iss_asrc = '0; iss_src_en = '0; ret_valid = '0; ret_ard = '0; flush = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;

    // Reset state, then a load to r5 and a dependent consumer.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 5, 0, 1, 1, 5, 0, 0, 0);   // retire r5 alongside consumer
    drive(1, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
    idle(1);

    // Saturation on r3, then drain.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    idle(1);

    // Issue + double retire to r7 nets to zero; a further retire underflows.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 7, 0, 0, 0, 3, 7, 7, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    idle(2);

    // Flush with a simultaneous issue and retire.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 6, 0, 0, 0, 1, 2, 0, 1, 0);
    idle(1);

    // x0 is never tracked.
    drive(1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    idle(1);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3),
            (($urandom_range(0, 9) < 3) ? 1 : 0) | (($urandom_range(0, 9) < 3) ? 2 : 0),
            $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 99) < 3) ? 1 : 0,
            ($urandom_range(0, 99) < 1) ? 1 : 0);
    end
    idle(2);

    for (int i = 0; i < 10 && (exp_q_a.size() > 0 || exp_q_b.size() > 0); i++) begin
      @(negedge clock);
    end
    #1;
    if (exp_q_a.size() > 0 || exp_q_b.size() > 0) begin
      n_bad++;
      $display("FAIL drain got=%0d/%0d pending exp=0", exp_q_a.size(), exp_q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
